// File: rtl/lagarto_fpu_pkg.sv
// rtl/lagarto_fpu_pkg.sv - shared types and constants for the vector FP multiply sequencer
package lagarto_fpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        READ,
        CAPT,
        ISSUE,
        WAIT,
        WRITE,
        DONE
    } vseq_state_t;

    localparam logic [1:0] SEW32 = 2'b10;
    localparam logic [1:0] SEW64 = 2'b11;

endpackage

// File: rtl/vseq_tail_be.sv
// rtl/vseq_tail_be.sv - byte enables for one result chunk, masking lanes past vl on the last chunk
module vseq_tail_be
    import lagarto_fpu_pkg::*;
#(
    parameter int VL_W   = 5,
    parameter int CIDX_W = 2
) (
    input  logic [1:0]        vsew,
    input  logic [VL_W-1:0]   vl,
    input  logic [CIDX_W-1:0] chunk,
    input  logic [VL_W-1:0]   nchunks,
    output logic [15:0]       be
);

    logic              last;
    logic [VL_W+1:0]   base;
    logic [VL_W+1:0]   rem;
    logic [VL_W+1:0]   lane;

    always_comb begin
        last = ({{(VL_W-CIDX_W){1'b0}}, chunk} == (nchunks - VL_W'(1)));
        // elements already covered by the full chunks before this one
        if (vsew == SEW64) begin
            base = {2'b00, nchunks - VL_W'(1)} << 1;
        end else begin
            base = {2'b00, nchunks - VL_W'(1)} << 2;
        end
        rem  = {2'b00, vl} - base;
        lane = '0;
        be   = 16'hFFFF;
        if (last) begin
            for (int b = 0; b < 16; b++) begin
                lane  = (vsew == SEW64) ? (VL_W+2)'(b / 8) : (VL_W+2)'(b / 4);
                be[b] = (lane < rem);
            end
        end
    end

endmodule

// File: rtl/vfp_mul_sequencer.sv
// rtl/vfp_mul_sequencer.sv - walks a vector multiply request chunk by chunk through RF read, FU launch and RF write
module vfp_mul_sequencer
    import lagarto_fpu_pkg::*;
#(
    parameter int VLEN    = 512,
    parameter int CHUNK_W = 128,
    parameter int TIMEOUT = 64,
    parameter int CIDX_W  = $clog2(VLEN/128),
    localparam int VL_W   = $clog2(VLEN/32) + 1,
    localparam int AW     = 5 + CIDX_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [1:0]         req_vsew_i,
    input  logic [VL_W-1:0]    req_vl_i,
    input  logic [4:0]         req_vs1_i,
    input  logic [4:0]         req_vs2_i,
    input  logic [4:0]         req_vd_i,
    output logic               rf_rd_en_o,
    output logic [AW-1:0]      rf_rd_vs1_addr_o,
    output logic [AW-1:0]      rf_rd_vs2_addr_o,
    input  logic [CHUNK_W-1:0] rf_rd_vs1_data_i,
    input  logic [CHUNK_W-1:0] rf_rd_vs2_data_i,
    output logic               fu_chip_enable_o,
    output logic [1:0]         fu_vsew_o,
    output logic [CHUNK_W-1:0] fu_vs1_o,
    output logic [CHUNK_W-1:0] fu_vs2_o,
    input  logic               fu_busy_i,
    input  logic               fu_done_i,
    input  logic [CHUNK_W-1:0] fu_vd_i,
    output logic               rf_wr_en_o,
    output logic [AW-1:0]      rf_wr_addr_o,
    output logic [CHUNK_W-1:0] rf_wr_data_o,
    output logic [15:0]        rf_wr_be_o,
    output logic               cmpl_valid_o,
    output logic               cmpl_error_o
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [VL_W-1:0] VLMAX32 = VL_W'(VLEN / 32);
    localparam logic [VL_W-1:0] VLMAX64 = VL_W'(VLEN / 64);

    vseq_state_t       state;
    logic [1:0]        vsew_q;
    logic [VL_W-1:0]   vl_q;
    logic [VL_W-1:0]   nch_q;
    logic [4:0]        vs1_q;
    logic [4:0]        vs2_q;
    logic [4:0]        vd_q;
    logic [CIDX_W-1:0] chunk;
    logic [TW-1:0]     tcnt;

    logic [VL_W:0]     vl_ext;
    logic [VL_W:0]     nch_calc;
    logic              illegal;
    logic              chunk_last;
    logic [15:0]       tail_be;

    // nchunks = ceil(vl / EPC), evaluated on the incoming request so it can be latched at accept
    always_comb begin
        vl_ext = {1'b0, req_vl_i};
        if (req_vsew_i == SEW64) begin
            nch_calc = (vl_ext + (VL_W+1)'(1)) >> 1;
        end else begin
            nch_calc = (vl_ext + (VL_W+1)'(3)) >> 2;
        end
    end

    always_comb begin
        illegal = 1'b0;
        if (vsew_q == SEW32) begin
            illegal = (vl_q > VLMAX32);
        end else if (vsew_q == SEW64) begin
            illegal = (vl_q > VLMAX64);
        end else begin
            illegal = 1'b1;
        end
        chunk_last = ({{(VL_W-CIDX_W){1'b0}}, chunk} == (nch_q - VL_W'(1)));
    end

    vseq_tail_be #(
        .VL_W   (VL_W),
        .CIDX_W (CIDX_W)
    ) u_tail_be (
        .vsew    (vsew_q),
        .vl      (vl_q),
        .chunk   (chunk),
        .nchunks (nch_q),
        .be      (tail_be)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state            <= IDLE;
            req_ready_o      <= 1'b1;
            vsew_q           <= '0;
            vl_q             <= '0;
            nch_q            <= '0;
            vs1_q            <= '0;
            vs2_q            <= '0;
            vd_q             <= '0;
            chunk            <= '0;
            tcnt             <= '0;
            rf_rd_en_o       <= 1'b0;
            rf_rd_vs1_addr_o <= '0;
            rf_rd_vs2_addr_o <= '0;
            fu_chip_enable_o <= 1'b0;
            fu_vsew_o        <= '0;
            fu_vs1_o         <= '0;
            fu_vs2_o         <= '0;
            rf_wr_en_o       <= 1'b0;
            rf_wr_addr_o     <= '0;
            rf_wr_data_o     <= '0;
            rf_wr_be_o       <= '0;
            cmpl_valid_o     <= 1'b0;
            cmpl_error_o     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        vsew_q      <= req_vsew_i;
                        vl_q        <= req_vl_i;
                        nch_q       <= nch_calc[VL_W-1:0];
                        vs1_q       <= req_vs1_i;
                        vs2_q       <= req_vs2_i;
                        vd_q        <= req_vd_i;
                        req_ready_o <= 1'b0;
                        state       <= CHECK;
                    end
                end
                CHECK: begin
                    if (illegal) begin
                        cmpl_valid_o <= 1'b1;
                        cmpl_error_o <= 1'b1;
                        state        <= DONE;
                    end else if (vl_q == '0) begin
                        cmpl_valid_o <= 1'b1;
                        state        <= DONE;
                    end else begin
                        chunk            <= '0;
                        rf_rd_en_o       <= 1'b1;
                        rf_rd_vs1_addr_o <= {vs1_q, CIDX_W'(0)};
                        rf_rd_vs2_addr_o <= {vs2_q, CIDX_W'(0)};
                        state            <= READ;
                    end
                end
                READ: begin
                    rf_rd_en_o <= 1'b0;
                    state      <= CAPT;
                end
                CAPT: begin
                    fu_vs1_o  <= rf_rd_vs1_data_i;
                    fu_vs2_o  <= rf_rd_vs2_data_i;
                    fu_vsew_o <= vsew_q;
                    state     <= ISSUE;
                end
                ISSUE: begin
                    if (!fu_busy_i) begin
                        fu_chip_enable_o <= 1'b1;
                        tcnt             <= '0;
                        state            <= WAIT;
                    end
                end
                WAIT: begin
                    fu_chip_enable_o <= 1'b0;
                    // a done coinciding with the launch cycle belongs to an older operation
                    if (fu_done_i && !fu_chip_enable_o) begin
                        rf_wr_en_o   <= 1'b1;
                        rf_wr_addr_o <= {vd_q, chunk};
                        rf_wr_data_o <= fu_vd_i;
                        rf_wr_be_o   <= tail_be;
                        state        <= WRITE;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        cmpl_valid_o <= 1'b1;
                        cmpl_error_o <= 1'b1;
                        state        <= DONE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                WRITE: begin
                    rf_wr_en_o <= 1'b0;
                    rf_wr_be_o <= '0;
                    if (chunk_last) begin
                        cmpl_valid_o <= 1'b1;
                        state        <= DONE;
                    end else begin
                        chunk            <= chunk + CIDX_W'(1);
                        rf_rd_en_o       <= 1'b1;
                        rf_rd_vs1_addr_o <= {vs1_q, chunk + CIDX_W'(1)};
                        rf_rd_vs2_addr_o <= {vs2_q, chunk + CIDX_W'(1)};
                        state            <= READ;
                    end
                end
                DONE: begin
                    cmpl_valid_o <= 1'b0;
                    cmpl_error_o <= 1'b0;
                    req_ready_o  <= 1'b1;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vfp_mul_sequencer.sv
// tb/tb_vfp_mul_sequencer.sv - self-checking bench with RF and FU models and a write scoreboard
module tb_vfp_mul_sequencer;
    import lagarto_fpu_pkg::*;

    localparam int VLEN    = 512;
    localparam int TIMEOUT = 64;
    localparam int VL_W    = 5;
    localparam int AW      = 7;

    logic           clk = 1'b0;
    logic           rst_i = 1'b1;
    logic           req_valid = 1'b0;
    logic           req_ready_o;
    logic [1:0]     req_vsew = '0;
    logic [VL_W-1:0] req_vl = '0;
    logic [4:0]     req_vs1 = '0, req_vs2 = '0, req_vd = '0;
    logic           rf_rd_en_o;
    logic [AW-1:0]  rf_rd_vs1_addr_o, rf_rd_vs2_addr_o;
    logic [127:0]   rf_rd_vs1_data = '0, rf_rd_vs2_data = '0;
    logic           fu_chip_enable_o;
    logic [1:0]     fu_vsew_o;
    logic [127:0]   fu_vs1_o, fu_vs2_o;
    logic           fu_busy = 1'b0;
    logic           fu_done;
    logic           fu_done_m = 1'b0;
    logic           spur = 1'b0;
    logic [127:0]   fu_vd = '0;
    logic           rf_wr_en_o;
    logic [AW-1:0]  rf_wr_addr_o;
    logic [127:0]   rf_wr_data_o;
    logic [15:0]    rf_wr_be_o;
    logic           cmpl_valid_o, cmpl_error_o;

    assign fu_done = fu_done_m | spur;

    vfp_mul_sequencer #(.VLEN(VLEN), .CHUNK_W(128), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o),
        .req_vsew_i(req_vsew), .req_vl_i(req_vl),
        .req_vs1_i(req_vs1), .req_vs2_i(req_vs2), .req_vd_i(req_vd),
        .rf_rd_en_o(rf_rd_en_o),
        .rf_rd_vs1_addr_o(rf_rd_vs1_addr_o), .rf_rd_vs2_addr_o(rf_rd_vs2_addr_o),
        .rf_rd_vs1_data_i(rf_rd_vs1_data), .rf_rd_vs2_data_i(rf_rd_vs2_data),
        .fu_chip_enable_o(fu_chip_enable_o), .fu_vsew_o(fu_vsew_o),
        .fu_vs1_o(fu_vs1_o), .fu_vs2_o(fu_vs2_o),
        .fu_busy_i(fu_busy), .fu_done_i(fu_done), .fu_vd_i(fu_vd),
        .rf_wr_en_o(rf_wr_en_o), .rf_wr_addr_o(rf_wr_addr_o),
        .rf_wr_data_o(rf_wr_data_o), .rf_wr_be_o(rf_wr_be_o),
        .cmpl_valid_o(cmpl_valid_o), .cmpl_error_o(cmpl_error_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [127:0]  data;
        logic [15:0]   be;
    } wr_t;

    typedef struct {
        logic [1:0] sew;
        int vl, vs1, vs2, vd, lat;
        int nwr;
        logic err;
        int lat_exp;
    } vec_t;

    wr_t exp_q[$];
    wr_t e;
    int n_vec = 0, n_fail = 0;
    int n_wr_tot = 0, n_ce_tot = 0, n_rd_tot = 0, cmpl_cnt = 0;
    int ce_cyc = 0, rd_cyc = 0, cmpl_cyc = 0;
    logic cmpl_err = 1'b0;
    logic [127:0] last_wr_data = '0;
    logic [127:0] rf_mem [32][4];
    int fu_cnt = 0, fu_lat = 3;
    bit fu_enable = 1'b1;
    logic [127:0] fu_res = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // FU stand-in: real multiply per 64-bit lane for SEW64, lane-wise xor for SEW32
    function automatic logic [127:0] fu_calc(input logic [1:0] sew, input logic [127:0] a, input logic [127:0] b);
        logic [127:0] r;
        if (sew == SEW64) begin
            for (int l = 0; l < 2; l++)
                r[64*l +: 64] = $realtobits($bitstoreal(a[64*l +: 64]) * $bitstoreal(b[64*l +: 64]));
        end else begin
            r = a ^ b;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rf_rd_en_o) begin
            n_rd_tot++;
            rd_cyc = cyc;
            rf_rd_vs1_data = rf_mem[rf_rd_vs1_addr_o[6:2]][rf_rd_vs1_addr_o[1:0]];
            rf_rd_vs2_data = rf_mem[rf_rd_vs2_addr_o[6:2]][rf_rd_vs2_addr_o[1:0]];
        end
    end

    always @(negedge clk) begin
        fu_done_m = 1'b0;
        if (fu_chip_enable_o) begin
            n_ce_tot++;
            ce_cyc = cyc;
            fu_res = fu_calc(fu_vsew_o, fu_vs1_o, fu_vs2_o);
            fu_cnt = fu_enable ? fu_lat : 0;
        end else if (fu_cnt > 0) begin
            fu_cnt--;
            if (fu_cnt == 0) begin
                fu_done_m = 1'b1;
                fu_vd = fu_res;
            end
        end
    end

    always @(negedge clk) begin
        if (rf_wr_en_o) begin
            n_wr_tot++;
            last_wr_data = rf_wr_data_o;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", rf_wr_addr_o, e.addr);
                chk("wr_data", rf_wr_data_o, e.data);
                chk("wr_be", rf_wr_be_o, e.be);
            end
        end
        if (cmpl_valid_o) begin
            cmpl_cnt++;
            cmpl_err = cmpl_error_o;
            cmpl_cyc = cyc;
        end
    end

    task automatic start_req(input logic [1:0] sew, input int vl, input int vs1, input int vs2,
                             input int vd, input int push_n, output int drv_cyc);
        int epc, lb, nch, r;
        wr_t w;
        bit legal;
        for (int i = 0; i < 100 && !req_ready_o; i++) begin
            @(negedge clk); #1;
        end
        chk("req_ready_before_req", req_ready_o, 1);
        epc   = (sew == SEW64) ? 2 : 4;
        lb    = (sew == SEW64) ? 8 : 4;
        nch   = (vl + epc - 1) / epc;
        legal = (sew == SEW32 || sew == SEW64) && (vl <= VLEN / (lb * 8));
        if (legal) begin
            for (int c = 0; c < nch && c < push_n; c++) begin
                r      = vl - (nch - 1) * epc;
                w.addr = AW'(vd * 4 + c);
                w.data = fu_calc(sew, rf_mem[vs1][c], rf_mem[vs2][c]);
                w.be   = (c < nch - 1) ? 16'hFFFF : 16'((1 << (r * lb)) - 1);
                exp_q.push_back(w);
            end
        end
        req_vsew  = sew;
        req_vl    = VL_W'(vl);
        req_vs1   = 5'(vs1);
        req_vs2   = 5'(vs2);
        req_vd    = 5'(vd);
        req_valid = 1'b1;
        drv_cyc   = cyc;
        @(negedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_cmpl(input int base);
        for (int i = 0; i < 600 && cmpl_cnt == base; i++) begin
            @(negedge clk); #1;
        end
        chk("cmpl_seen", cmpl_cnt - base, 1);
        @(negedge clk); #1;
    endtask

    vec_t vt[9];
    int b_wr, b_ce, b_rd, b_c, dc;

    initial begin
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 4; c++)
                rf_mem[r][c] = {$urandom, $urandom, $urandom, $urandom};
        for (int c = 0; c < 4; c++) begin
            rf_mem[7][c] = {2{64'h3FF8000000000000}};
            rf_mem[8][c] = {2{64'h4000000000000000}};
        end

        //        sew    vl  vs1 vs2 vd lat nwr err lat_exp
        vt[0] = '{SEW32,  8,  1,  2,  3, 3,  2, 0, 0};
        vt[1] = '{SEW32,  5,  4,  5,  6, 1,  2, 0, 0};
        vt[2] = '{SEW64,  3,  7,  8,  9, 2,  2, 0, 0};
        vt[3] = '{SEW32,  0,  1,  2,  3, 3,  0, 0, 2};
        vt[4] = '{2'b01,  4,  1,  2,  3, 3,  0, 1, 2};
        vt[5] = '{SEW64,  9,  7,  8,  9, 3,  0, 1, 2};
        vt[6] = '{SEW32, 16, 10, 11, 12, 4,  4, 0, 0};
        vt[7] = '{SEW64,  8,  7,  8, 13, 1,  4, 0, 0};
        vt[8] = '{SEW32, 17,  1,  2,  3, 3,  0, 1, 2};

        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", req_ready_o, 1);
        chk("rst_rd_en", rf_rd_en_o, 0);
        chk("rst_ce", fu_chip_enable_o, 0);
        chk("rst_wr_en", rf_wr_en_o, 0);
        chk("rst_cmpl", cmpl_valid_o, 0);
        chk("rst_be", rf_wr_be_o, 0);
        chk("rst_fu_vs1", fu_vs1_o, 0);
        rst_i = 1'b0;
        @(negedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            fu_lat = vt[i].lat;
            b_wr = n_wr_tot; b_ce = n_ce_tot; b_rd = n_rd_tot; b_c = cmpl_cnt;
            start_req(vt[i].sew, vt[i].vl, vt[i].vs1, vt[i].vs2, vt[i].vd, 99, dc);
            wait_cmpl(b_c);
            chk($sformatf("v%0d_nwr", i), n_wr_tot - b_wr, vt[i].nwr);
            chk($sformatf("v%0d_nce", i), n_ce_tot - b_ce, vt[i].nwr);
            chk($sformatf("v%0d_nrd", i), n_rd_tot - b_rd, vt[i].nwr);
            chk($sformatf("v%0d_err", i), cmpl_err, vt[i].err);
            chk($sformatf("v%0d_sb_empty", i), exp_q.size(), 0);
            if (vt[i].lat_exp != 0)
                chk($sformatf("v%0d_cmpl_latency", i), cmpl_cyc - dc, vt[i].lat_exp);
            if (i == 2)
                chk("sew64_golden_3p0", last_wr_data, {2{64'h4008000000000000}});
        end

        // FU busy for 5 cycles in ISSUE delays the launch by 5 cycles
        fu_lat = 2;
        fu_busy = 1'b1;
        b_rd = n_rd_tot; b_c = cmpl_cnt;
        start_req(SEW32, 4, 4, 5, 14, 99, dc);
        for (int i = 0; i < 50 && n_rd_tot == b_rd; i++) begin
            @(negedge clk); #1;
        end
        repeat (7) @(negedge clk);
        #1;
        fu_busy = 1'b0;
        wait_cmpl(b_c);
        chk("busy_ce_delay", ce_cyc - rd_cyc, 8);
        chk("busy_err", cmpl_err, 0);

        // withheld done: abort after TIMEOUT cycles in WAIT
        fu_enable = 1'b0;
        b_wr = n_wr_tot; b_c = cmpl_cnt;
        start_req(SEW32, 4, 1, 2, 15, 0, dc);
        wait_cmpl(b_c);
        chk("timeout_err", cmpl_err, 1);
        chk("timeout_cycles", cmpl_cyc - ce_cyc, TIMEOUT);
        chk("timeout_nwr", n_wr_tot - b_wr, 0);
        fu_enable = 1'b1;

        // spurious done while idle
        b_wr = n_wr_tot; b_c = cmpl_cnt;
        spur = 1'b1;
        @(negedge clk); #1;
        spur = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("spur_nwr", n_wr_tot - b_wr, 0);
        chk("spur_ncmpl", cmpl_cnt - b_c, 0);
        chk("spur_ready", req_ready_o, 1);

        // reset during WAIT of chunk 1
        fu_lat = 10;
        b_wr = n_wr_tot; b_ce = n_ce_tot; b_c = cmpl_cnt;
        start_req(SEW32, 8, 1, 2, 16, 1, dc);
        for (int i = 0; i < 200 && n_ce_tot != b_ce + 2; i++) begin
            @(negedge clk); #1;
        end
        chk("rstmid_second_launch", n_ce_tot - b_ce, 2);
        rst_i = 1'b1;
        @(negedge clk); #1;
        chk("rstmid_ready", req_ready_o, 1);
        chk("rstmid_wr_en", rf_wr_en_o, 0);
        chk("rstmid_no_cmpl", cmpl_cnt - b_c, 0);
        rst_i = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        chk("rstmid_nwr", n_wr_tot - b_wr, 1);
        chk("rstmid_no_cmpl_later", cmpl_cnt - b_c, 0);
        chk("rstmid_sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule
